// File: rtl/uart_tx_pid_framer.sv
// PID link transmit framer: snapshots y1/y2 and emits AA/PID/VALUE/55 frames into a byte-wide UART TX.
// Optional build macro UART_TX_TEST_FRAME_EN appends a PID 0x69 frame carrying y1[7:0].
module uart_tx_pid_framer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [31:0] y1,
  input  logic [31:0] y2,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        done
);

  // state  | meaning
  // IDLE   | waiting for send, busy low
  // START  | tx_start pulse cycle for the current byte
  // WAIT   | byte in flight, waiting for tx_done
  // GAP    | idle spacing between frames
  // FIN    | done pulse, returns to IDLE
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GAP, S_FIN} state_t;

`ifdef UART_TX_TEST_FRAME_EN
  localparam logic [3:0] LAST_FRAME = 4'd8;
`else
  localparam logic [3:0] LAST_FRAME = 4'd7;
`endif

  state_t      state_q;
  logic [3:0]  frame_q;
  logic [1:0]  byte_q;
  logic [7:0]  gap_q;
  logic [31:0] w1_q, w2_q;
  logic        tx_start_q, busy_q, done_q;
  logic [7:0]  tx_byte_q;

  // Frames 0-3 carry w1 MSB first, 4-7 carry w2, frame 8 is the test frame.
  function automatic logic [7:0] frame_byte(input logic [3:0] f, input logic [1:0] b,
                                            input logic [31:0] a1, input logic [31:0] a2);
    logic [31:0] word;
    logic [7:0]  pid, val;
    word = f[2] ? a2 : a1;
    pid  = {2'b00, f[2] ? 2'b10 : 2'b01, 2'b00, f[1:0]};
    case (f[1:0])
      2'd0:    val = word[31:24];
      2'd1:    val = word[23:16];
      2'd2:    val = word[15:8];
      default: val = word[7:0];
    endcase
`ifdef UART_TX_TEST_FRAME_EN
    if (f[3]) begin
      pid = 8'h69;
      val = a1[7:0];
    end
`endif
    case (b)
      2'd0:    frame_byte = 8'hAA;
      2'd1:    frame_byte = pid;
      2'd2:    frame_byte = val;
      default: frame_byte = 8'h55;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frame_q    <= 4'd0;
      byte_q     <= 2'd0;
      gap_q      <= 8'd0;
      w1_q       <= 32'd0;
      w2_q       <= 32'd0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (send) begin
            w1_q       <= y1;
            w2_q       <= y2;
            frame_q    <= 4'd0;
            byte_q     <= 2'd0;
            busy_q     <= 1'b1;
            tx_start_q <= 1'b1;
            tx_byte_q  <= 8'hAA;
            state_q    <= S_START;
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (tx_done) begin
            if (byte_q != 2'd3) begin
              byte_q     <= byte_q + 2'd1;
              tx_start_q <= 1'b1;
              tx_byte_q  <= frame_byte(frame_q, byte_q + 2'd1, w1_q, w2_q);
              state_q    <= S_START;
            end else if (frame_q == LAST_FRAME) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              frame_q <= frame_q + 4'd1;
              byte_q  <= 2'd0;
              if (GAP_CYCLES == 0) begin
                tx_start_q <= 1'b1;
                tx_byte_q  <= 8'hAA;
                state_q    <= S_START;
              end else begin
                gap_q   <= 8'(GAP_CYCLES - 1);
                state_q <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_q == 8'd0) begin
            tx_start_q <= 1'b1;
            tx_byte_q  <= 8'hAA;
            state_q    <= S_START;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/uart_tx_pid_framer.md
# uart_tx_pid_framer

Transmit-side framer for the PID parameter link. On a `send` request it snapshots two 32-bit words and serialises them as 4-byte frames (0xAA, PID, VALUE, 0x55), one byte at a time, into the existing byte-wide UART transmitter. It produces exactly the frame stream the receive-side PID buffer decodes into its `a1`/`a2` words. The block sits between the control core (word source) and the UART TX serialiser (byte sink).

## Interface
Parameters:
- `GAP_CYCLES`, default 0: idle clock cycles inserted after each frame's 0x55 byte completes, before the next frame's 0xAA. Legal range 0..255.

Ports:
- `clk`  input  1  single system clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `send`  input  1  request; sampled only while `busy`=0
- `y1`  input  32  word 1; captured on accepted `send`
- `y2`  input  32  word 2; captured on accepted `send`
- `tx_done`  input  1  1-cycle pulse from UART TX: current byte fully shifted out
- `tx_start`  output  1  1-cycle pulse: UART TX loads `tx_byte`
- `tx_byte`  output  8  byte to transmit; held stable from `tx_start` until the matching `tx_done`
- `busy`  output  1  high from the cycle after an accepted `send` until `done`
- `done`  output  1  1-cycle pulse after the last byte's `tx_done`

## Operation
- Frame order: PIDs 0x10, 0x11, 0x12, 0x13 carry `y1[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`. PIDs 0x20..0x23 carry `y2` bytes in the same MSB-first order.
- Each frame is sent as bytes 0xAA, PID, VALUE, 0x55.
- Total: 8 frames, 32 bytes (see Configuration for the optional extra frame).
- Every byte costs one `tx_start` pulse followed by a wait for `tx_done`.
- FSM states:
  - IDLE: `busy`=0. On `send`=1, latch `y1`/`y2`, clear frame index and byte index, go to START.
  - START: assert `tx_start` for 1 cycle with `tx_byte` = current byte; go to WAIT.
  - WAIT: hold `tx_byte`. On `tx_done`:
    - if byte index < 3: increment it, go to START;
    - else if last frame: go to FIN;
    - else: increment frame index, clear byte index, go to GAP.
  - GAP: count `GAP_CYCLES` cycles, then go to START. With `GAP_CYCLES`=0 this state is bypassed and WAIT goes directly to START.
  - FIN: pulse `done`, go to IDLE.
- Latched words are not affected by `y1`/`y2` changes while `busy`=1.
- `send` while `busy`=1 is ignored; it is not queued.
- `tx_done` outside WAIT is ignored.

## Timing
- Reset values: `tx_start`=0, `tx_byte`=0x00, `busy`=0, `done`=0, state=IDLE, indices=0, latched words=0.
- `send` high at edge N (IDLE) -> `busy`=1 and `tx_start`=1 with `tx_byte`=0xAA at edge N+1.
- `tx_done` at edge M, within a frame -> next `tx_start` at M+1.
- `tx_done` on a frame's 0x55 byte at edge M, not the last frame -> next 0xAA `tx_start` at M+1+`GAP_CYCLES`.
- Last `tx_done` at edge M -> `done`=1 at M+1, `busy`=0 at M+2. A new `send` is accepted at M+2.
- `tx_done` in the same cycle as `tx_start` is ignored.
- Reset asserted mid-transfer -> next edge returns all outputs to reset values. No partial frame is resumed.
- `rst` and `send` both high -> reset wins.

## Configuration
- `UART_TX_TEST_FRAME_EN` defined: after the y2 frames, one extra frame is sent with PID 0x69 and VALUE = `y1[7:0]`. Total 36 bytes; `done` follows that frame's 0x55.
- Not defined: 32 bytes only. PID 0x69 is never emitted.

## Test plan
- Reset, then `send` with `y1`=0x12345678, `y2`=0x9ABCDEF0, `tx_done` 3 cycles after each `tx_start` -> byte stream AA 10 12 55, AA 11 34 55, AA 12 56 55, AA 13 78 55, AA 20 9A 55, AA 21 BC 55, AA 22 DE 55, AA 23 F0 55; one `done` pulse; 32 `tx_start` pulses total.
- Same stimulus with `UART_TX_TEST_FRAME_EN` defined -> stream additionally ends with AA 69 78 55; 36 `tx_start` pulses.
- `GAP_CYCLES`=5 -> exactly 5 cycles between the `tx_done` of each 0x55 byte and the next 0xAA `tx_start`; no gap inside a frame.
- `send` pulsed again and `y1` changed to 0xFFFFFFFF mid-transfer -> stream unchanged from the first test; no second transfer starts.
- `rst` asserted after the 10th `tx_done` -> next cycle `busy`=0, `tx_start`=0, `tx_byte`=0x00; a following `send` restarts from AA 10.
- Spurious `tx_done` pulses while IDLE and in the `tx_start` cycle -> no byte skipped; stream identical to the first test.
